// File: rtl/button_conditioner_pkg.sv
// -----------------------------------------------------------------------------
// button_conditioner_pkg
// Shared definitions for the push-button conditioner: button bit positions in
// the {center,left,right,up,down} vector, the default auto-repeat mask and the
// fixed-priority selector used to keep the press pulses one-hot.
// -----------------------------------------------------------------------------
package button_conditioner_pkg;

    localparam int unsigned NUM_BTN    = 5;

    // Bit positions inside btn_raw / btn_held
    localparam int unsigned BTN_CENTER = 4;
    localparam int unsigned BTN_LEFT   = 3;
    localparam int unsigned BTN_RIGHT  = 2;
    localparam int unsigned BTN_UP     = 1;
    localparam int unsigned BTN_DOWN   = 0;

    // Auto-repeat on up and down only
    localparam logic [NUM_BTN-1:0] REPEAT_EN_DEFAULT = 5'b00011;

    // Fixed priority center > left > right > up > down. Exactly the highest
    // ranked requesting bit survives; all others are dropped.
    function automatic logic [NUM_BTN-1:0] prio_select(input logic [NUM_BTN-1:0] ev);
        logic [NUM_BTN-1:0] sel;
        sel = 5'b00000;
        if (ev[BTN_CENTER]) begin
            sel[BTN_CENTER] = 1'b1;
        end else if (ev[BTN_LEFT]) begin
            sel[BTN_LEFT] = 1'b1;
        end else if (ev[BTN_RIGHT]) begin
            sel[BTN_RIGHT] = 1'b1;
        end else if (ev[BTN_UP]) begin
            sel[BTN_UP] = 1'b1;
        end else if (ev[BTN_DOWN]) begin
            sel[BTN_DOWN] = 1'b1;
        end else begin
            sel = 5'b00000;
        end
        return sel;
    endfunction

endpackage

// File: rtl/button_conditioner_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// One button: two-flop synchroniser followed by a counting debouncer.
// Ports:
//   clk        in  - clock
//   rst_n      in  - asynchronous active-low reset
//   raw        in  - asynchronous raw button level (active-high)
//   level      out - debounced level (registered)
//   level_next out - value the debounced level takes on the next edge
//   press      out - high in the cycle before level rises (0->1 only)
// -----------------------------------------------------------------------------
module btn_debounce
    import button_conditioner_pkg::*;
#(
    parameter int DEBOUNCE_CYC = 3
) (
    input  logic clk,
    input  logic rst_n,
    input  logic raw,
    output logic level,
    output logic level_next,
    output logic press
);

    localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE_CYC);

    logic [1:0] sync_r;
    logic       db_r;
    logic [3:0] cnt_r;
    logic       db_next_s;
    logic [3:0] cnt_next_s;

    // Two-flop synchroniser for the asynchronous raw level
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_r <= 2'b00;
        end else begin
            sync_r <= {sync_r[0], raw};
        end
    end

    // Debounce next-state: count disagreeing samples, flip once the run is long enough
    always_comb begin
        db_next_s  = db_r;
        cnt_next_s = cnt_r;
        if (sync_r[1] == db_r) begin
            cnt_next_s = 4'd0;
        end else if ((cnt_r + 4'd1) == DB_LIMIT) begin
            db_next_s  = ~db_r;
            cnt_next_s = 4'd0;
        end else begin
            cnt_next_s = cnt_r + 4'd1;
        end
    end

    // Debounce state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            db_r  <= 1'b0;
            cnt_r <= 4'd0;
        end else begin
            db_r  <= db_next_s;
            cnt_r <= cnt_next_s;
        end
    end

    // The press event is taken from the next state so the registered pulse in
    // the top level rises on the same edge as the debounced level.
    assign level      = db_r;
    assign level_next = db_next_s;
    assign press      = db_next_s & ~db_r;

endmodule

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Synchronises, debounces and auto-repeats the five board buttons and emits
// one-hot single-cycle press pulses for the countdown control block.
// Ports:
//   clk_core      in  - 100 Hz system clock
//   rst_n         in  - asynchronous active-low reset
//   btn_raw[4:0]  in  - raw levels {center,left,right,up,down}
//   center_button, left_button, right_button, up_button, down_button
//                 out - registered press pulses, at most one high per cycle
//   btn_held[4:0] out - registered debounced levels, same order as btn_raw
// -----------------------------------------------------------------------------
module button_conditioner
    import button_conditioner_pkg::*;
#(
    parameter int          DEBOUNCE_CYC = 3,
    parameter int          REPEAT_DELAY = 50,
    parameter int          REPEAT_RATE  = 10,
    parameter logic [4:0]  REPEAT_EN    = REPEAT_EN_DEFAULT
) (
    input  logic       clk_core,
    input  logic       rst_n,
    input  logic [4:0] btn_raw,
    output logic       center_button,
    output logic       left_button,
    output logic       right_button,
    output logic       up_button,
    output logic       down_button,
    output logic [4:0] btn_held
);

    localparam logic [7:0] RPT_DELAY_W = 8'(REPEAT_DELAY);
    localparam logic [7:0] RPT_RATE_W  = 8'(REPEAT_RATE);

    logic [4:0] db_next_s;
    logic [4:0] press_s;
    logic [4:0] rpt_ev_s;
    logic [4:0] event_s;
    logic [4:0] pulse_next_s;
    logic [4:0] pulse_r;

    genvar i;
    generate
        for (i = 0; i < NUM_BTN; i++) begin : g_btn
            localparam logic [4:0] OTHER_MASK = ~(5'b00001 << i);

            logic [7:0] rpt_r;
            logic [7:0] rpt_next_s;
            logic       rpt_hit_s;
            logic       others_held_s;

            btn_debounce #(
                .DEBOUNCE_CYC (DEBOUNCE_CYC)
            ) u_debounce (
                .clk        (clk_core),
                .rst_n      (rst_n),
                .raw        (btn_raw[i]),
                .level      (btn_held[i]),
                .level_next (db_next_s[i]),
                .press      (press_s[i])
            );

            assign others_held_s = |(btn_held & OTHER_MASK);

            // Repeat counter next-state; disabled buttons fold to a constant zero.
            // Counting requires the level to stay high into the next cycle so a
            // repeat can never coincide with the release edge.
            always_comb begin
                rpt_next_s = rpt_r;
                rpt_hit_s  = 1'b0;
                if (!REPEAT_EN[i]) begin
                    rpt_next_s = 8'd0;
                end else if (press_s[i]) begin
                    rpt_next_s = RPT_DELAY_W;
                end else if (btn_held[i] && db_next_s[i]) begin
                    if (others_held_s) begin
                        rpt_next_s = rpt_r;
                    end else if (rpt_r == 8'd1) begin
                        rpt_hit_s  = 1'b1;
                        rpt_next_s = RPT_RATE_W;
                    end else if (rpt_r != 8'd0) begin
                        rpt_next_s = rpt_r - 8'd1;
                    end else begin
                        rpt_next_s = rpt_r;
                    end
                end else begin
                    rpt_next_s = 8'd0;
                end
            end

            // Repeat counter register
            always_ff @(posedge clk_core or negedge rst_n) begin
                if (!rst_n) begin
                    rpt_r <= 8'd0;
                end else begin
                    rpt_r <= rpt_next_s;
                end
            end

            assign rpt_ev_s[i] = rpt_hit_s;
        end
    endgenerate

    assign event_s      = press_s | rpt_ev_s;
    assign pulse_next_s = prio_select(event_s);

    // Registered one-hot pulse outputs
    always_ff @(posedge clk_core or negedge rst_n) begin
        if (!rst_n) begin
            pulse_r <= 5'b00000;
        end else begin
            pulse_r <= pulse_next_s;
        end
    end

    assign center_button = pulse_r[BTN_CENTER];
    assign left_button   = pulse_r[BTN_LEFT];
    assign right_button  = pulse_r[BTN_RIGHT];
    assign up_button     = pulse_r[BTN_UP];
    assign down_button   = pulse_r[BTN_DOWN];

endmodule

// File: tb/tb_button_conditioner.sv
// Directed bench for button_conditioner with default parameters.
// Edge k means the k-th rising edge after btn_raw changes; outputs are
// sampled on the following falling edge.
module tb_button_conditioner;

    logic       clk_core;
    logic       rst_n;
    logic [4:0] btn_raw;
    logic       center_button;
    logic       left_button;
    logic       right_button;
    logic       up_button;
    logic       down_button;
    logic [4:0] btn_held;
    logic [4:0] pulses;

    int n_vec;
    int n_err;
    int up_count;

    button_conditioner dut (
        .clk_core      (clk_core),
        .rst_n         (rst_n),
        .btn_raw       (btn_raw),
        .center_button (center_button),
        .left_button   (left_button),
        .right_button  (right_button),
        .up_button     (up_button),
        .down_button   (down_button),
        .btn_held      (btn_held)
    );

    assign pulses = {center_button, left_button, right_button, up_button, down_button};

    initial clk_core = 1'b0;
    always #5 clk_core = ~clk_core;

    task automatic check_value(input string tag, input logic [4:0] obs, input logic [4:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_err++;
            $display("FAIL %s: observed %b, expected %b", tag, obs, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk_core);
        @(negedge clk_core);
    endtask

    task automatic idle(input int n);
        for (int j = 0; j < n; j++) step();
    endtask

    initial begin
        n_vec    = 0;
        n_err    = 0;
        up_count = 0;
        rst_n    = 1'b0;
        btn_raw  = 5'b00000;

        // Reset state
        @(negedge clk_core);
        @(negedge clk_core);
        check_value("reset_pulses", pulses, 5'b00000);
        check_value("reset_held", btn_held, 5'b00000);
        rst_n = 1'b1;
        idle(3);

        // Clean centre press, then release
        btn_raw = 5'b10000;
        for (int k = 0; k < 20; k++) begin
            step();
            check_value($sformatf("clean_pulse_e%0d", k), pulses, (k == 4) ? 5'b10000 : 5'b00000);
            check_value($sformatf("clean_held_e%0d", k), btn_held, (k >= 4) ? 5'b10000 : 5'b00000);
        end
        btn_raw = 5'b00000;
        for (int k = 0; k < 8; k++) begin
            step();
            check_value($sformatf("rel_pulse_e%0d", k), pulses, 5'b00000);
            check_value($sformatf("rel_held_e%0d", k), btn_held, (k < 4) ? 5'b10000 : 5'b00000);
        end

        // Bounce on up: 1,0,1,1,0 then steady 1 -> single pulse 4 edges after final rise
        btn_raw = 5'b00010; step(); check_value("bounce_b0", pulses, 5'b00000);
        btn_raw = 5'b00000; step(); check_value("bounce_b1", pulses, 5'b00000);
        btn_raw = 5'b00010; step(); check_value("bounce_b2", pulses, 5'b00000);
        btn_raw = 5'b00010; step(); check_value("bounce_b3", pulses, 5'b00000);
        btn_raw = 5'b00000; step(); check_value("bounce_b4", pulses, 5'b00000);
        btn_raw = 5'b00010;
        for (int k = 0; k < 20; k++) begin
            step();
            if (up_button) up_count++;
            check_value($sformatf("bounce_pulse_e%0d", k), pulses, (k == 4) ? 5'b00010 : 5'b00000);
        end
        btn_raw = 5'b00000;
        for (int k = 0; k < 10; k++) begin
            step();
            if (up_button) up_count++;
        end
        check_value("bounce_count", 5'(up_count), 5'd1);

        // Auto-repeat on down, held 100 cycles
        btn_raw = 5'b00001;
        for (int k = 0; k < 120; k++) begin
            logic exp_p;
            if (k == 100) btn_raw = 5'b00000;
            step();
            exp_p = (k == 4) || (k == 54) || (k == 64) || (k == 74) || (k == 84) || (k == 94);
            check_value($sformatf("rpt_pulse_e%0d", k), pulses, exp_p ? 5'b00001 : 5'b00000);
            check_value($sformatf("rpt_held_e%0d", k), btn_held,
                        (k >= 4 && k < 104) ? 5'b00001 : 5'b00000);
        end

        // Simultaneous left + right: only left pulses
        btn_raw = 5'b01100;
        for (int k = 0; k < 10; k++) begin
            step();
            check_value($sformatf("simul_pulse_e%0d", k), pulses, (k == 4) ? 5'b01000 : 5'b00000);
            check_value($sformatf("simul_held_e%0d", k), btn_held, (k >= 4) ? 5'b01100 : 5'b00000);
        end
        btn_raw = 5'b00000;
        idle(8);

        // Repeat freeze: up pressed, centre joins at press+30, both released at edge 70
        btn_raw = 5'b00010;
        for (int k = 0; k < 90; k++) begin
            logic [4:0] exp_p;
            if (k == 34) btn_raw = 5'b10010;
            if (k == 70) btn_raw = 5'b00000;
            step();
            exp_p = (k == 4) ? 5'b00010 : ((k == 38) ? 5'b10000 : 5'b00000);
            check_value($sformatf("freeze_pulse_e%0d", k), pulses, exp_p);
        end

        // Reset mid-hold on down
        btn_raw = 5'b00001;
        for (int k = 0; k < 59; k++) begin
            step();
            check_value($sformatf("rsthold_pulse_e%0d", k), pulses,
                        (k == 4 || k == 54) ? 5'b00001 : 5'b00000);
        end
        rst_n = 1'b0;
        #1;
        check_value("rst_async_pulses", pulses, 5'b00000);
        check_value("rst_async_held", btn_held, 5'b00000);
        for (int k = 0; k < 2; k++) begin
            step();
            check_value($sformatf("rst_low_pulses_%0d", k), pulses, 5'b00000);
            check_value($sformatf("rst_low_held_%0d", k), btn_held, 5'b00000);
        end
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            step();
            check_value($sformatf("after_rst_pulse_e%0d", k), pulses, (k == 4) ? 5'b00001 : 5'b00000);
            check_value($sformatf("after_rst_held_e%0d", k), btn_held, (k >= 4) ? 5'b00001 : 5'b00000);
        end
        btn_raw = 5'b00000;
        idle(6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
